reorder_buffer: RTL and testbench

- Circular reorder buffer that allocates in-order tags at issue and collects results from the common data bus.
- Retires entries in program order, producing the commit write stream (rd, value, tag) consumed by the register file.
- Register file clears its pending tag when the committed tag matches.
- On a committed branch mispredict, raises a one-cycle rollback with the redirect PC and flushes all entries.

---
 rtl/reorder_buffer.sv | 183 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer
//  Purpose  : Circular in-order tag allocator that collects CDB results and
//             retires in program order, flushing on a committed mispredict.
//  Revision : 1.0  initial release
// ============================================================================
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int ROB_WID  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               issue_valid,
    input  logic [4:0]         issue_rd,
    input  logic               issue_is_br,
    output logic [ROB_WID-1:0] issue_pos,
    output logic               full,
    input  logic               wb_valid,
    input  logic [ROB_WID-1:0] wb_pos,
    input  logic [31:0]        wb_val,
    input  logic               wb_mispred,
    input  logic [31:0]        wb_target,
    input  logic [ROB_WID-1:0] q1_pos,
    output logic               q1_ready,
    output logic [31:0]        q1_val,
    input  logic [ROB_WID-1:0] q2_pos,
    output logic               q2_ready,
    output logic [31:0]        q2_val,
    output logic               commit_valid,
    output logic [4:0]         commit_rd,
    output logic [31:0]        commit_val,
    output logic [ROB_WID-1:0] commit_pos,
    output logic               rollback,
    output logic [31:0]        rollback_pc
);

    localparam logic [ROB_WID-1:0] PTR_ONE  = ROB_WID'(1);
    localparam logic [ROB_WID:0]   CNT_ONE  = (ROB_WID+1)'(1);
    localparam logic [ROB_WID:0]   CNT_FULL = (ROB_WID+1)'(ROB_SIZE);

    logic [ROB_SIZE-1:0] busy_q, busy_d, ready_q, ready_d;
    logic [ROB_SIZE-1:0] mispred_q, mispred_d, is_br_q, is_br_d;
    logic [4:0]          rd_q     [ROB_SIZE];
    logic [4:0]          rd_d     [ROB_SIZE];
    logic [31:0]         val_q    [ROB_SIZE];
    logic [31:0]         val_d    [ROB_SIZE];
    logic [31:0]         target_q [ROB_SIZE];
    logic [31:0]         target_d [ROB_SIZE];

    logic [ROB_WID-1:0]  head_q, head_d, tail_q, tail_d;
    logic [ROB_WID:0]    count_q, count_d;

    logic                commit_valid_q, commit_valid_d;
    logic [4:0]          commit_rd_q, commit_rd_d;
    logic [31:0]         commit_val_q, commit_val_d;
    logic [ROB_WID-1:0]  commit_pos_q, commit_pos_d;
    logic                rollback_q, rollback_d;
    logic [31:0]         rollback_pc_q, rollback_pc_d;

    logic w_commit_go, w_flush, w_issue_ok;

    assign full      = (count_q == CNT_FULL);
    assign issue_pos = tail_q;
    assign q1_ready  = busy_q[q1_pos] & ready_q[q1_pos];
    assign q1_val    = val_q[q1_pos];
    assign q2_ready  = busy_q[q2_pos] & ready_q[q2_pos];
    assign q2_val    = val_q[q2_pos];

    assign commit_valid = commit_valid_q;
    assign commit_rd    = commit_rd_q;
    assign commit_val   = commit_val_q;
    assign commit_pos   = commit_pos_q;
    assign rollback     = rollback_q;
    assign rollback_pc  = rollback_pc_q;

    assign w_commit_go = (count_q != '0) && ready_q[head_q];
    assign w_flush     = w_commit_go && is_br_q[head_q] && mispred_q[head_q];
    // A full buffer still accepts an issue on an edge that frees the head slot.
    assign w_issue_ok  = issue_valid && (!full || w_commit_go) && !w_flush;

    always_comb begin
        busy_d         = busy_q;
        ready_d        = ready_q;
        mispred_d      = mispred_q;
        is_br_d        = is_br_q;
        rd_d           = rd_q;
        val_d          = val_q;
        target_d       = target_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_valid_d = 1'b0;
        commit_rd_d    = commit_rd_q;
        commit_val_d   = commit_val_q;
        commit_pos_d   = commit_pos_q;
        rollback_d     = 1'b0;
        rollback_pc_d  = rollback_pc_q;

        if (rdy) begin
            if (wb_valid && busy_q[wb_pos]) begin
                ready_d[wb_pos]   = 1'b1;
                val_d[wb_pos]     = wb_val;
                mispred_d[wb_pos] = wb_mispred;
                target_d[wb_pos]  = wb_target;
            end
            if (w_commit_go) begin
                commit_valid_d  = 1'b1;
                commit_rd_d     = rd_q[head_q];
                commit_val_d    = val_q[head_q];
                commit_pos_d    = head_q;
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = head_q + PTR_ONE;
            end
            // Issue after commit so a slot freed and refilled on one edge ends busy.
            if (w_issue_ok) begin
                busy_d[tail_q]    = 1'b1;
                ready_d[tail_q]   = 1'b0;
                mispred_d[tail_q] = 1'b0;
                is_br_d[tail_q]   = issue_is_br;
                rd_d[tail_q]      = issue_rd;
                tail_d            = tail_q + PTR_ONE;
            end
            unique case ({w_issue_ok, w_commit_go})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (w_flush) begin
                rollback_d    = 1'b1;
                rollback_pc_d = target_q[head_q];
                busy_d        = '0;
                ready_d       = '0;
                mispred_d     = '0;
                head_d        = '0;
                tail_d        = '0;
                count_d       = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q         <= '0;
            ready_q        <= '0;
            mispred_q      <= '0;
            is_br_q        <= '0;
            rd_q           <= '{default: '0};
            val_q          <= '{default: '0};
            target_q       <= '{default: '0};
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_val_q   <= '0;
            commit_pos_q   <= '0;
            rollback_q     <= 1'b0;
            rollback_pc_q  <= '0;
        end else begin
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            mispred_q      <= mispred_d;
            is_br_q        <= is_br_d;
            rd_q           <= rd_d;
            val_q          <= val_d;
            target_q       <= target_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_rd_q    <= commit_rd_d;
            commit_val_q   <= commit_val_d;
            commit_pos_q   <= commit_pos_d;
            rollback_q     <= rollback_d;
            rollback_pc_q  <= rollback_pc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reorder_buffer
//  Purpose  : Directed vector table plus hand sequences for reorder_buffer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_is_br = 1'b0;
    logic [3:0]  issue_pos;
    logic        full;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_pos = '0;
    logic [31:0] wb_val = '0;
    logic        wb_mispred = 1'b0;
    logic [31:0] wb_target = '0;
    logic [3:0]  q1_pos = '0;
    logic        q1_ready;
    logic [31:0] q1_val;
    logic [3:0]  q2_pos = '0;
    logic        q2_ready;
    logic [31:0] q2_val;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic [3:0]  commit_pos;
    logic        rollback;
    logic [31:0] rollback_pc;

    int n_vec  = 0;
    int n_fail = 0;

    reorder_buffer #(.ROB_SIZE(16), .ROB_WID(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_br(issue_is_br),
        .issue_pos(issue_pos), .full(full),
        .wb_valid(wb_valid), .wb_pos(wb_pos), .wb_val(wb_val),
        .wb_mispred(wb_mispred), .wb_target(wb_target),
        .q1_pos(q1_pos), .q1_ready(q1_ready), .q1_val(q1_val),
        .q2_pos(q2_pos), .q2_ready(q2_ready), .q2_val(q2_val),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_val(commit_val),
        .commit_pos(commit_pos), .rollback(rollback), .rollback_pc(rollback_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned iv, ird, wv, wpos, wval, qpos;
        int unsigned e_cv, e_crd, e_cval, e_cpos, e_ipos, e_qr, e_qv;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_rd = '0; issue_is_br = 1'b0;
        wb_valid = 1'b0; wb_pos = '0; wb_val = '0; wb_mispred = 1'b0; wb_target = '0;
    endtask

    task automatic do_reset();
        idle();
        rdy = 1'b1;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic issue1(input logic [4:0] rd, input logic br);
        idle();
        issue_valid = 1'b1; issue_rd = rd; issue_is_br = br;
        step();
    endtask

    task automatic wb1(input logic [3:0] pos, input logic [31:0] v,
                       input logic mis, input logic [31:0] tgt);
        idle();
        wb_valid = 1'b1; wb_pos = pos; wb_val = v; wb_mispred = mis; wb_target = tgt;
        step();
    endtask

    initial begin
        //        iv ird wv wpos wval     qpos  cv crd cval     cpos ipos qr qv
        tbl[0]  = '{1, 5, 0, 0, 0,        0,    0, 0, 0,        0,   1,   0, 0};
        tbl[1]  = '{0, 0, 1, 0, 32'h1234, 0,    0, 0, 0,        0,   1,   1, 32'h1234};
        tbl[2]  = '{0, 0, 0, 0, 0,        0,    1, 5, 32'h1234, 0,   1,   0, 32'h1234};
        tbl[3]  = '{1, 1, 0, 0, 0,        1,    0, 5, 32'h1234, 0,   2,   0, 0};
        tbl[4]  = '{1, 2, 0, 0, 0,        1,    0, 5, 32'h1234, 0,   3,   0, 0};
        tbl[5]  = '{1, 3, 0, 0, 0,        3,    0, 5, 32'h1234, 0,   4,   0, 0};
        tbl[6]  = '{0, 0, 1, 3, 32'h33,   3,    0, 5, 32'h1234, 0,   4,   1, 32'h33};
        tbl[7]  = '{0, 0, 1, 2, 32'h22,   2,    0, 5, 32'h1234, 0,   4,   1, 32'h22};
        tbl[8]  = '{0, 0, 1, 1, 32'h11,   1,    0, 5, 32'h1234, 0,   4,   1, 32'h11};
        tbl[9]  = '{0, 0, 0, 0, 0,        1,    1, 1, 32'h11,   1,   4,   0, 32'h11};
        tbl[10] = '{0, 0, 0, 0, 0,        2,    1, 2, 32'h22,   2,   4,   0, 32'h22};
        tbl[11] = '{0, 0, 0, 0, 0,        3,    1, 3, 32'h33,   3,   4,   0, 32'h33};
        tbl[12] = '{0, 0, 1, 5, 32'hdead, 5,    0, 3, 32'h33,   3,   4,   0, 0};
        tbl[13] = '{1, 0, 0, 0, 0,        4,    0, 3, 32'h33,   3,   5,   0, 0};
        tbl[14] = '{0, 0, 1, 4, 32'h44,   4,    0, 3, 32'h33,   3,   5,   1, 32'h44};
        tbl[15] = '{0, 0, 0, 0, 0,        4,    1, 0, 32'h44,   4,   5,   0, 32'h44};

        do_reset();
        chk("reset_full", 32'(full), 0);
        chk("reset_issue_pos", 32'(issue_pos), 0);
        chk("reset_commit_valid", 32'(commit_valid), 0);
        chk("reset_rollback", 32'(rollback), 0);
        chk("reset_commit_val", commit_val, 0);

        // Table: single retire, out-of-order writeback, ignored wb, rd=0 commit.
        for (int i = 0; i < 16; i++) begin
            idle();
            issue_valid = tbl[i].iv[0];
            issue_rd    = 5'(tbl[i].ird);
            wb_valid    = tbl[i].wv[0];
            wb_pos      = 4'(tbl[i].wpos);
            wb_val      = tbl[i].wval;
            q1_pos      = 4'(tbl[i].qpos);
            step();
            chk($sformatf("v%0d_commit_valid", i), 32'(commit_valid), tbl[i].e_cv);
            chk($sformatf("v%0d_commit_rd", i), 32'(commit_rd), tbl[i].e_crd);
            chk($sformatf("v%0d_commit_val", i), commit_val, tbl[i].e_cval);
            chk($sformatf("v%0d_commit_pos", i), 32'(commit_pos), tbl[i].e_cpos);
            chk($sformatf("v%0d_issue_pos", i), 32'(issue_pos), tbl[i].e_ipos);
            chk($sformatf("v%0d_q1_ready", i), 32'(q1_ready), tbl[i].e_qr);
            chk($sformatf("v%0d_q1_val", i), q1_val, tbl[i].e_qv);
            chk($sformatf("v%0d_full", i), 32'(full), 0);
            chk($sformatf("v%0d_rollback", i), 32'(rollback), 0);
        end

        // Full, wrap, and simultaneous issue+commit at full.
        do_reset();
        for (int i = 0; i < 16; i++) issue1(5'(i + 1), 1'b0);
        chk("fill_full", 32'(full), 1);
        chk("fill_issue_pos", 32'(issue_pos), 0);
        issue1(5'd31, 1'b0);
        chk("overflow_full", 32'(full), 1);
        chk("overflow_issue_pos", 32'(issue_pos), 0);
        wb1(4'd0, 32'ha0, 1'b0, 32'h0);
        chk("wb_at_full_no_commit", 32'(commit_valid), 0);
        idle();
        step();
        chk("wrap_commit_valid", 32'(commit_valid), 1);
        chk("wrap_commit_rd", 32'(commit_rd), 1);
        chk("wrap_commit_val", commit_val, 32'ha0);
        chk("wrap_not_full", 32'(full), 0);
        chk("wrap_issue_pos", 32'(issue_pos), 0);
        issue1(5'd20, 1'b0);
        chk("wrap_refill_pos", 32'(issue_pos), 1);
        chk("wrap_refill_full", 32'(full), 1);
        wb1(4'd1, 32'ha1, 1'b0, 32'h0);
        issue1(5'd21, 1'b0);
        chk("simul_commit_valid", 32'(commit_valid), 1);
        chk("simul_commit_pos", 32'(commit_pos), 1);
        chk("simul_full", 32'(full), 1);
        chk("simul_issue_pos", 32'(issue_pos), 2);
        q1_pos = 4'd1;
        #1;
        chk("simul_slot_not_ready", 32'(q1_ready), 0);
        wb1(4'd1, 32'h77, 1'b0, 32'h0);
        chk("simul_slot_busy_ready", 32'(q1_ready), 1);
        chk("simul_slot_val", q1_val, 32'h77);
        // Asynchronous reset mid-operation.
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_full", 32'(full), 0);
        chk("async_rst_issue_pos", 32'(issue_pos), 0);
        chk("async_rst_q1_ready", 32'(q1_ready), 0);
        step();
        rst = 1'b1;

        // Mispredict with same-edge issue and writeback discarded.
        do_reset();
        issue1(5'd1, 1'b1);
        issue1(5'd2, 1'b0);
        issue1(5'd3, 1'b0);
        issue1(5'd4, 1'b0);
        wb1(4'd0, 32'h4, 1'b1, 32'h80);
        idle();
        issue_valid = 1'b1; issue_rd = 5'd9;
        wb_valid = 1'b1; wb_pos = 4'd2; wb_val = 32'h55;
        step();
        chk("mis_commit_valid", 32'(commit_valid), 1);
        chk("mis_commit_pos", 32'(commit_pos), 0);
        chk("mis_commit_val", commit_val, 32'h4);
        chk("mis_rollback", 32'(rollback), 1);
        chk("mis_rollback_pc", rollback_pc, 32'h80);
        chk("mis_issue_pos", 32'(issue_pos), 0);
        q2_pos = 4'd2;
        wb1(4'd1, 32'h99, 1'b0, 32'h0);
        chk("post_rollback_low", 32'(rollback), 0);
        chk("post_commit_low", 32'(commit_valid), 0);
        chk("post_full", 32'(full), 0);
        q1_pos = 4'd1;
        #1;
        chk("old_tag1_ignored", 32'(q1_ready), 0);
        chk("old_tag2_ignored", 32'(q2_ready), 0);
        idle();
        step();
        chk("no_commit_after_flush", 32'(commit_valid), 0);
        chk("issue_pos_after_flush", 32'(issue_pos), 0);

        // rdy gating with a ready head.
        do_reset();
        issue1(5'd7, 1'b0);
        wb1(4'd0, 32'h5a, 1'b0, 32'h0);
        idle();
        rdy = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd8;
        q1_pos = 4'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rdy_low%0d_commit", i), 32'(commit_valid), 0);
            chk($sformatf("rdy_low%0d_issue_pos", i), 32'(issue_pos), 1);
            chk($sformatf("rdy_low%0d_q1_ready", i), 32'(q1_ready), 1);
        end
        idle();
        rdy = 1'b1;
        step();
        chk("rdy_back_commit", 32'(commit_valid), 1);
        chk("rdy_back_commit_rd", 32'(commit_rd), 7);
        chk("rdy_back_commit_val", commit_val, 32'h5a);
        step();
        chk("rdy_back_pulse_end", 32'(commit_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
